// File: rtl/color_matrix_pipeline_if.sv
// Pixel stream bundle: packed pixel plus valid/ready handshake.
// The producer drives pixel/valid and the consumer drives ready.
interface color_matrix_pipeline_if #(
  parameter int W = 24
);
  logic [W-1:0] pixel;
  logic         valid;
  logic         ready;

  modport master (
    output pixel,
    output valid,
    input  ready
  );

  modport slave (
    input  pixel,
    input  valid,
    output ready
  );
endinterface

// File: rtl/color_matrix_pipeline.sv
// 3x3 signed fixed-point colour matrix, 3-stage pipeline with backpressure.
// Matrix updates go through a shadow register applied on a drained pipe.
module color_matrix_pipeline #(
  parameter int CH_W   = 8,
  parameter int COEF_W = 32,
  parameter int FRAC   = 16,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  color_matrix_pipeline_if.slave  in_s,
  color_matrix_pipeline_if.master out_s,
  input  logic                  in_bgr,
  input  logic                  out_bgr,
  input  logic [9*COEF_W-1:0]   matrix_in,
  input  logic                  matrix_load,
  output logic                  matrix_pending,
  output logic                  busy,
  output logic [CNT_W-1:0]      pixel_count,
  output logic [CNT_W-1:0]      sat_count
);

  localparam int PX_W = 3 * CH_W;
  localparam int P_W  = COEF_W + CH_W + 1;
  localparam int S_W  = P_W + 2;
  localparam int M_W  = 9 * COEF_W;

  function automatic logic [M_W-1:0] ident();
    logic [M_W-1:0] m;
    m = '0;
    for (int i = 0; i < 3; i++) begin
      m[4*i*COEF_W + FRAC] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [M_W-1:0] IDENT = ident();

  logic [M_W-1:0]        active;
  logic [M_W-1:0]        shadow;
  logic                  en;
  logic                  in_ready_w;
  logic                  accept;
  logic                  drained;

  logic [CH_W-1:0]       rgb [3];
  logic signed [P_W-1:0] prod [9];

  logic                  s1_valid;
  logic                  s1_obgr;
  logic signed [P_W-1:0] s1_prod [9];

  logic                  s2_valid;
  logic                  s2_obgr;
  logic signed [S_W-1:0] s2_sum [3];

  logic signed [S_W:0]   half;
  logic signed [S_W:0]   rnd [3];
  logic signed [S_W:0]   shr [3];
  logic [CH_W-1:0]       res [3];
  logic [2:0]            flag;
  logic [1:0]            sat_n;
  logic [PX_W-1:0]       packed_px;

  logic                  out_valid_q;
  logic [PX_W-1:0]       out_pixel_q;
  logic [1:0]            out_sat;

  assign en         = !out_valid_q || out_s.ready;
  assign in_ready_w = en && !matrix_pending && !rst;
  assign accept     = in_s.valid && in_ready_w;
  assign drained    = !s1_valid && !s2_valid && !out_valid_q;

  assign in_s.ready  = in_ready_w;
  assign out_s.valid = out_valid_q;
  assign out_s.pixel = out_pixel_q;
  assign busy        = !drained || matrix_pending;

  always_comb begin
    rgb[0] = in_bgr ? in_s.pixel[CH_W-1:0]
                    : in_s.pixel[PX_W-1 -: CH_W];
    rgb[1] = in_s.pixel[2*CH_W-1 -: CH_W];
    rgb[2] = in_bgr ? in_s.pixel[PX_W-1 -: CH_W]
                    : in_s.pixel[CH_W-1:0];
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        prod[3*i+j] =
          P_W'($signed(active[(3*i+j)*COEF_W +: COEF_W])) *
          P_W'($signed({1'b0, rgb[j]}));
      end
    end
  end

  // Round half up, then clamp to the channel range.
  always_comb begin
    half = '0;
    half[FRAC-1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd[i]  = (S_W+1)'(s2_sum[i]) + half;
      shr[i]  = rnd[i] >>> FRAC;
      res[i]  = shr[i][CH_W-1:0];
      flag[i] = 1'b0;
      if (shr[i][S_W]) begin
        res[i]  = '0;
        flag[i] = 1'b1;
      end else if (|shr[i][S_W-1:CH_W]) begin
        res[i]  = '1;
        flag[i] = 1'b1;
      end
    end
    sat_n = 2'(flag[0]) + 2'(flag[1]) + 2'(flag[2]);
    packed_px = s2_obgr ? {res[2], res[1], res[0]}
                        : {res[0], res[1], res[2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_obgr     <= 1'b0;
      s2_valid    <= 1'b0;
      s2_obgr     <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_sat     <= '0;
    end else if (en) begin
      s1_valid    <= accept;
      s2_valid    <= s1_valid;
      out_valid_q <= s2_valid;
      if (accept) begin
        s1_prod <= prod;
        s1_obgr <= out_bgr;
      end
      if (s1_valid) begin
        for (int i = 0; i < 3; i++) begin
          s2_sum[i] <= S_W'(s1_prod[3*i]) +
                       S_W'(s1_prod[3*i+1]) +
                       S_W'(s1_prod[3*i+2]);
        end
        s2_obgr <= s1_obgr;
      end
      if (s2_valid) begin
        out_pixel_q <= packed_px;
        out_sat     <= sat_n;
      end
    end
  end

  // A load arriving on the swap edge keeps pending set for the next swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      active         <= IDENT;
      shadow         <= IDENT;
      matrix_pending <= 1'b0;
      pixel_count    <= '0;
      sat_count      <= '0;
    end else begin
      if (matrix_pending && drained) begin
        active         <= shadow;
        matrix_pending <= 1'b0;
      end
      if (matrix_load) begin
        shadow         <= matrix_in;
        matrix_pending <= 1'b1;
      end
      if (out_valid_q && out_s.ready) begin
        pixel_count <= pixel_count + 1'b1;
        sat_count   <= sat_count + CNT_W'(out_sat);
      end
    end
  end

endmodule

// File: tb/tb_color_matrix_pipeline.sv
// Randomised scoreboard bench for color_matrix_pipeline.
// Expected pixels come from an arithmetic model of the matrix rules.
module tb_color_matrix_pipeline;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_bgr = 1'b0;
  logic         out_bgr = 1'b0;
  logic [287:0] matrix_in = '0;
  logic         matrix_load = 1'b0;
  logic         matrix_pending;
  logic         busy;
  logic [31:0]  pixel_count;
  logic [31:0]  sat_count;

  color_matrix_pipeline_if #(.W(24)) in_if ();
  color_matrix_pipeline_if #(.W(24)) out_if ();

  color_matrix_pipeline #(
    .CH_W(8), .COEF_W(32), .FRAC(16), .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_s(in_if.slave),
    .out_s(out_if.master),
    .in_bgr(in_bgr),
    .out_bgr(out_bgr),
    .matrix_in(matrix_in),
    .matrix_load(matrix_load),
    .matrix_pending(matrix_pending),
    .busy(busy),
    .pixel_count(pixel_count),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] px;
    int          sat;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t         q[$];
  int           compared = 0;
  int           mismatched = 0;
  int           cyc = 0;
  int           m_pix = 0;
  int           m_sat = 0;
  int           rmode = 0;
  bit           lat_mode = 1'b0;
  logic [287:0] m_cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic [287:0] diag(input int a, input int b,
                                        input int c);
    logic [287:0] m;
    m = '0;
    m[0*32 +: 32] = a;
    m[4*32 +: 32] = b;
    m[8*32 +: 32] = c;
    return m;
  endfunction

  function automatic logic [287:0] rand_mat();
    logic [287:0] m;
    for (int k = 0; k < 9; k++)
      m[k*32 +: 32] = int'($urandom_range(0, 262144)) - 131072;
    return m;
  endfunction

  // out = clamp(floor((M * rgb + 0.5) in Q16)), channel order per flags
  function automatic void ref_px(input logic [23:0] p, input bit ib,
                                 input bit ob, input logic [287:0] m,
                                 output logic [23:0] o, output int sat);
    longint c[3];
    longint s;
    logic [7:0] v[3];
    c[0] = ib ? p[7:0] : p[23:16];
    c[1] = p[15:8];
    c[2] = ib ? p[23:16] : p[7:0];
    sat = 0;
    for (int i = 0; i < 3; i++) begin
      s = 0;
      for (int j = 0; j < 3; j++)
        s += longint'($signed(m[(3*i+j)*32 +: 32])) * c[j];
      s = (s + 32768) >>> 16;
      if (s < 0) begin
        s = 0;
        sat++;
      end else if (s > 255) begin
        s = 255;
        sat++;
      end
      v[i] = s[7:0];
    end
    o = ob ? {v[2], v[1], v[0]} : {v[0], v[1], v[2]};
  endfunction

  task automatic send(input logic [23:0] p, input bit ib, input bit ob,
                      input bit ld, input logic [287:0] mat);
    int   n = 0;
    bit   done = 1'b0;
    exp_t e;
    while (!done) begin
      @(negedge clk);
      in_if.valid = 1'b1;
      in_if.pixel = p;
      in_bgr      = ib;
      out_bgr     = ob;
      matrix_load = ld && (n == 0);
      matrix_in   = mat;
      #1;
      if (in_if.ready) begin
        ref_px(p, ib, ob, m_cur, e.px, e.sat);
        e.acc = cyc;
        e.lat = lat_mode;
        q.push_back(e);
        done = 1'b1;
      end
      if (matrix_load) m_cur = mat;
      n++;
      if (!done && n > 1000) begin
        chk("send_timeout", 64'(n), 64'(0));
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    matrix_load = 1'b0;
  endtask

  task automatic load(input logic [287:0] mat);
    @(negedge clk);
    matrix_load = 1'b1;
    matrix_in   = mat;
    m_cur       = mat;
    @(posedge clk);
    #1;
    matrix_load = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      #3;
      if (!busy && q.size() == 0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 64'(q.size()), 64'(0));
  endtask

  task automatic wait_swap();
    bit done = 1'b0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      #1;
      if (!matrix_pending) done = 1'b1;
    end
    if (!done) chk("swap_timeout", 64'(matrix_pending), 64'(0));
  endtask

  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      case (rmode)
        1: begin
          out_if.ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
        2: out_if.ready = 1'($urandom_range(0, 1));
        default: out_if.ready = 1'b1;
      endcase
    end
  end

  initial begin
    bit          prev_stall = 1'b0;
    logic [23:0] prev_pix = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(out_if.valid), 64'(1));
          chk("hold_pixel", 64'(out_if.pixel), 64'(prev_pix));
        end
        if (out_if.valid && out_if.ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 64'(out_if.pixel), 64'(0));
          end else begin
            e = q.pop_front();
            chk("pixel", 64'(out_if.pixel), 64'(e.px));
            if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(3));
            m_pix++;
            m_sat += e.sat;
          end
        end
        prev_stall = out_if.valid && !out_if.ready;
        prev_pix   = out_if.pixel;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] t1 [6];
    logic [287:0] idm;
    t1 = '{24'hFF0000, 24'h00FF00, 24'h0000FF,
           24'hFFFF00, 24'h00FFFF, 24'hFF00FF};
    idm = diag(65536, 65536, 65536);
    m_cur = idm;
    in_if.valid = 1'b0;
    in_if.pixel = '0;
    out_if.ready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_if.ready), 64'(0));
    chk("rst_out_valid", 64'(out_if.valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #3;
    chk("init_pending", 64'(matrix_pending), 64'(0));
    chk("init_pix_cnt", 64'(pixel_count), 64'(0));
    chk("init_sat_cnt", 64'(sat_count), 64'(0));
    chk("init_in_ready", 64'(in_if.ready), 64'(1));

    lat_mode = 1'b1;
    foreach (t1[i]) send(t1[i], 1'b0, 1'b0, 1'b0, '0);
    wait_idle();
    chk("t1_pix_cnt", 64'(pixel_count), 64'(6));
    chk("t1_sat_cnt", 64'(sat_count), 64'(0));

    send(24'hFF0000, 1'b1, 1'b0, 1'b0, '0);
    send(24'h123456, 1'b0, 1'b1, 1'b0, '0);
    wait_idle();
    lat_mode = 1'b0;

    load(diag(98304, 65536, 65536));
    send(24'hC80A0A, 1'b0, 1'b0, 1'b0, '0);
    wait_idle();
    chk("t3_sat_a", 64'(sat_count), 64'(1));
    load(diag(65536, -65536, 65536));
    send(24'h005000, 1'b0, 1'b0, 1'b0, '0);
    wait_idle();
    chk("t3_sat_b", 64'(sat_count), 64'(2));

    load(diag(32768, 32768, 32768));
    send(24'h030303, 1'b0, 1'b0, 1'b0, '0);
    send(24'h020202, 1'b0, 1'b0, 1'b0, '0);
    wait_idle();

    rmode = 1;
    load(rand_mat());
    for (int i = 0; i < 10; i++)
      send(24'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0);
    wait_idle();
    chk("t5_pix_cnt", 64'(pixel_count), 64'(m_pix));
    chk("t5_sat_cnt", 64'(sat_count), 64'(m_sat));

    rmode = 0;
    for (int i = 0; i < 3; i++)
      send(24'($urandom), 1'b0, 1'b0, 1'b0, '0);
    load(rand_mat());
    @(negedge clk);
    #1;
    chk("ld_pending", 64'(matrix_pending), 64'(1));
    chk("ld_in_ready", 64'(in_if.ready), 64'(0));
    wait_swap();
    @(negedge clk);
    #1;
    chk("swap_in_ready", 64'(in_if.ready), 64'(1));
    for (int i = 0; i < 5; i++)
      send(24'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0);

    rmode = 2;
    for (int i = 0; i < 60; i++)
      send(24'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 7) == 0, rand_mat());
    wait_idle();
    chk("rnd_pix_cnt", 64'(pixel_count), 64'(m_pix));
    chk("rnd_sat_cnt", 64'(sat_count), 64'(m_sat));

    load(rand_mat());
    for (int i = 0; i < 5; i++)
      send(24'($urandom), 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    m_pix = 0;
    m_sat = 0;
    m_cur = idm;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", 64'(out_if.valid), 64'(0));
    chk("mid_rst_pix", 64'(pixel_count), 64'(0));
    chk("mid_rst_sat", 64'(sat_count), 64'(0));
    chk("mid_rst_pend", 64'(matrix_pending), 64'(0));
    rst = 1'b0;
    rmode = 0;
    send(24'h9A4C21, 1'b0, 1'b0, 1'b0, '0);
    wait_idle();
    chk("post_rst_cnt", 64'(pixel_count), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
